// File: rtl/uart_mmio_responder_pkg.sv
// rtl/uart_mmio_responder_pkg.sv - IO address map, status bit indices and FSM encodings for the MMIO UART
package uart_mmio_responder_pkg;

    localparam logic [31:0] IO_UART_DATA  = 32'hBFD003F8;
    localparam logic [31:0] IO_UART_STATE = 32'hBFD003FC;

    localparam int STAT_TX_READY = 0;
    localparam int STAT_RX_VALID = 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous RX byte FIFO; push when full is dropped unless a pop frees the slot
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - memory-mapped UART serving CPU IO loads/stores (data + state ports)
// Define UART_RX_FIFO_EN to replace the single RX holding register with an RX_FIFO_DEPTH-entry FIFO.
module uart_mmio_responder
    import uart_mmio_responder_pkg::*;
#(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD          = 9600,
    parameter int CLKS_PER_BIT  = CLK_FREQ / BAUD,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_req,
    input  logic        io_sel,
    input  logic        io_we,
    input  logic [7:0]  io_wdata,
    output logic [31:0] io_rdata,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_txd;

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [1:0]       r_rxd_sync;

    logic             w_tx_ready;
    logic             w_tx_wr;
    logic             w_rxd;
    logic             w_rx_commit;
    logic             w_rd_pop;
    logic             w_rx_valid;
    logic [7:0]       w_rx_byte;

    assign w_tx_ready  = (r_tx_state == TX_IDLE);
    assign w_tx_wr     = io_req && io_we && !io_sel;
    assign w_rxd       = r_rxd_sync[1];
    assign w_rx_commit = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST) && w_rxd;
    assign w_rd_pop    = io_req && !io_we && !io_sel && w_rx_valid;
    assign uart_txd    = r_txd;

    // Writes arriving while a frame is in flight are dropped; software polls tx_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_tx_wr) begin
                        r_tx_shift <= io_wdata;
                        r_tx_cnt   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            r_txd    <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Start bit is re-checked at its midpoint; every later sample lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_sync <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rxd_sync <= {r_rxd_sync[0], uart_rxd};
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (!w_rxd) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic w_fifo_full;
    logic w_fifo_empty;

    uart_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_commit),
        .i_din   (r_rx_shift),
        .i_pop   (w_rd_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_rx_byte)
    );

    assign w_rx_valid = !w_fifo_empty;
`else
    logic       r_rx_valid;
    logic [7:0] r_rx_byte;

    // A commit wins over a same-cycle pop: the reader gets the old byte, the new one stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_byte  <= '0;
        end else if (w_rx_commit) begin
            r_rx_valid <= 1'b1;
            r_rx_byte  <= r_rx_shift;
        end else if (w_rd_pop) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign w_rx_valid = r_rx_valid;
    assign w_rx_byte  = r_rx_byte;
`endif

    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            io_rdata[STAT_TX_READY] = w_tx_ready;
            io_rdata[STAT_RX_VALID] = w_rx_valid;
        end else begin
            io_rdata[7:0] = w_rx_byte;
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb/tb_uart_mmio_responder.sv - self-checking bench for uart_mmio_responder (CLKS_PER_BIT=16)
module tb_uart_mmio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_req = 1'b0;
    logic        io_sel = 1'b0;
    logic        io_we = 1'b0;
    logic [7:0]  io_wdata = 8'h00;
    logic [31:0] io_rdata;
    logic        uart_txd;
    logic        uart_rxd = 1'b1;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         mon_en = 1'b1;

    uart_mmio_responder #(
        .CLK_FREQ      (16),
        .BAUD          (1),
        .RX_FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_req   (io_req),
        .io_sel   (io_sel),
        .io_we    (io_we),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .uart_txd (uart_txd),
        .uart_rxd (uart_rxd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic sel, input logic [7:0] d);
        io_req = 1'b1; io_we = 1'b1; io_sel = sel; io_wdata = d;
        step();
        io_req = 1'b0; io_we = 1'b0;
    endtask

    task automatic io_read(input logic sel, output logic [31:0] d);
        io_req = 1'b1; io_we = 1'b0; io_sel = sel;
        #1;
        d = io_rdata;
        step();
        io_req = 1'b0;
    endtask

    task automatic peek_state(output logic [31:0] d);
        io_sel = 1'b1;
        #1;
        d = io_rdata;
    endtask

    // Expected RX contents once a byte is committed by the DUT.
    task automatic rx_expect(input logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (rx_q.size() < 4) rx_q.push_back(b);
`else
        if (rx_q.size() == 0) rx_q.push_back(b);
        else rx_q[0] = b;
`endif
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (16) step();
        end
        uart_rxd = stop;
        repeat (16) step();
        uart_rxd = 1'b1;
        if (stop) rx_expect(b);
    endtask

    // TX frame decoder: samples mid-bit and checks against the expected-frame queue.
    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        logic       ok_start;
        logic       ok_stop;
        @(negedge rst);
        forever begin
            @(negedge uart_txd);
            repeat (8) step();
            ok_start = (uart_txd === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (16) step();
                got[i] = uart_txd;
            end
            repeat (16) step();
            ok_stop = (uart_txd === 1'b1);
            if (mon_en) begin
                n_checks++;
                if (tx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_frame unexpected frame got=%h expected=none", got);
                end else begin
                    exp = tx_q.pop_front();
                    if (got !== exp || !ok_start || !ok_stop) begin
                        n_fail++;
                        $display("FAIL tx_frame got=%h start_ok=%b stop_ok=%b expected=%h", got, ok_start, ok_stop, exp);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        io_read(1'b1, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL reset_state got=%h expected=%h", d, 32'h1); end
        n_checks++;
        if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b expected=1", uart_txd); end
        io_read(1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h expected=%h", d, 32'h0); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [9:0]  frame;
        frame = {1'b1, 8'h55, 1'b0};
        io_write(1'b0, 8'h55);
        tx_q.push_back(8'h55);
        for (int k = 1; k <= 160; k++) begin
            n_checks++;
            if (uart_txd !== frame[(k-1)/16]) begin
                n_fail++;
                $display("FAIL tx_level cycle=%0d got=%b expected=%b", k, uart_txd, frame[(k-1)/16]);
            end
            peek_state(d);
            n_checks++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL tx_busy_state cycle=%0d got=%h expected=%h", k, d, 32'h0); end
            step();
        end
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL tx_ready_161 got=%h expected=%h", d, 32'h1); end
    endtask

    task automatic test_tx_drop();
        logic [31:0] d;
        bit          done;
        bit          quiet;
        io_write(1'b0, 8'hA3);
        tx_q.push_back(8'hA3);
        repeat (4) step();
        peek_state(d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL drop_busy got=%h expected=%h", d, 32'h0); end
        io_write(1'b0, 8'hFF);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            peek_state(d);
            if (d[0] === 1'b1) done = 1'b1;
            else step();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL drop_idle_timeout got=busy expected=idle"); end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (uart_txd !== 1'b1) quiet = 1'b0;
            step();
        end
        n_checks++;
        if (!quiet) begin n_fail++; $display("FAIL drop_quiet got=activity expected=idle_line"); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bit          done;
        io_write(1'b0, 8'h0F);
        tx_q.push_back(8'h0F);
        repeat (160) step();
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL b2b_ready got=%h expected=%h", d, 32'h1); end
        io_write(1'b0, 8'hF0);
        tx_q.push_back(8'hF0);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            peek_state(d);
            if (d[0] === 1'b1) done = 1'b1;
            else step();
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL b2b_idle_timeout got=busy expected=idle"); end
        repeat (20) step();
    endtask

    task automatic test_rx();
        logic [31:0] d;
        logic [7:0]  exp;
        send_rx(8'h3C, 1'b1);
        peek_state(d);
        n_checks++;
        if (d !== 32'h3) begin n_fail++; $display("FAIL rx_state_valid got=%h expected=%h", d, 32'h3); end
        io_read(1'b0, d);
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        n_checks++;
        if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL rx_data got=%h expected=%h", d, {24'h0, exp}); end
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rx_state_popped got=%h expected=%h", d, 32'h1); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d;
        send_rx(8'h7E, 1'b0);
        repeat (20) step();
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rx_framing got=%h expected=%h", d, 32'h1); end
        uart_rxd = 1'b0;
        repeat (8) step();
        uart_rxd = 1'b1;
        repeat (200) step();
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL rx_glitch got=%h expected=%h", d, 32'h1); end
    endtask

    task automatic test_rx_read_collide();
        logic [31:0] d;
        logic [7:0]  exp;
        send_rx(8'h11, 1'b1);
        fork
            send_rx(8'h22, 1'b1);
            begin
                repeat (154) step();
                io_read(1'b0, d);
                exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
                n_checks++;
                if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL collide_old got=%h expected=%h", d, {24'h0, exp}); end
            end
        join
        peek_state(d);
        n_checks++;
        if (d !== 32'h3) begin n_fail++; $display("FAIL collide_valid got=%h expected=%h", d, 32'h3); end
        io_read(1'b0, d);
        exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        n_checks++;
        if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL collide_new got=%h expected=%h", d, {24'h0, exp}); end
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL collide_empty got=%h expected=%h", d, 32'h1); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic [7:0]  exp;
        int          n_reads;
        int          exp_reads;
`ifdef UART_RX_FIFO_EN
        exp_reads = 4;
`else
        exp_reads = 1;
`endif
        for (int b = 1; b <= 5; b++) send_rx(8'(b), 1'b1);
        n_reads = 0;
        while (rx_q.size() != 0 && n_reads < 8) begin
            peek_state(d);
            n_checks++;
            if (d !== 32'h3) begin n_fail++; $display("FAIL ovf_valid read=%0d got=%h expected=%h", n_reads, d, 32'h3); end
            io_read(1'b0, d);
            exp = rx_q.pop_front();
            n_checks++;
            if (d !== {24'h0, exp}) begin n_fail++; $display("FAIL ovf_data read=%0d got=%h expected=%h", n_reads, d, {24'h0, exp}); end
            n_reads++;
        end
        n_checks++;
        if (n_reads !== exp_reads) begin n_fail++; $display("FAIL ovf_count got=%0d expected=%0d", n_reads, exp_reads); end
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL ovf_drained got=%h expected=%h", d, 32'h1); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        mon_en = 1'b0;
        uart_rxd = 1'b0;
        io_write(1'b0, 8'h5A);
        repeat (80) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL midreset_txd got=%b expected=1", uart_txd); end
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL midreset_state got=%h expected=%h", d, 32'h1); end
        uart_rxd = 1'b1;
        rx_q.delete();
        repeat (3) step();
        rst = 1'b0;
        repeat (200) step();
        peek_state(d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL midreset_after got=%h expected=%h", d, 32'h1); end
        n_checks++;
        if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL midreset_line got=%b expected=1", uart_txd); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_drop();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        test_rx_read_collide();
        test_rx_overflow();
        n_checks++;
        if (tx_q.size() != 0) begin n_fail++; $display("FAIL tx_frames_missing got=%0d expected=0", tx_q.size()); end
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
